fifo_rd_ctrl: RTL

- Read-side sequencer for the bridge's asynchronous FIFO. Runs in the read (SPI) clock domain.
- Pops 41-bit request entries when the FIFO is non-empty and absorbs the FIFO's 1-cycle read latency.
- Holds each entry in an output register and presents it to the SPI command consumer over a valid/ready handshake, unpacked into write flag, address and write data.
- Supports flush and keeps pop/drop statistics.

---
 rtl/fifo_rd_ctrl_pkg.sv | 28 ++
 rtl/fifo_rd_ctrl_if.sv | 42 ++++
 rtl/fifo_rd_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and field layout for the bridge request FIFO read side.
// The write-side packer builds entries with the same cmd_entry_t layout.
package fifo_rd_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 41;
    localparam int unsigned ADDR_WIDTH_DEF  = 8;
    localparam int unsigned WDATA_WIDTH_DEF = 32;
    localparam int unsigned CNT_WIDTH_DEF   = 16;

    localparam int unsigned WRITE_BIT = 40;
    localparam int unsigned ADDR_MSB  = 39;
    localparam int unsigned ADDR_LSB  = 32;
    localparam int unsigned WDATA_MSB = 31;
    localparam int unsigned WDATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PRESENT = 2'd2
    } rd_ctrl_state_e;

    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } cmd_entry_t;

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus command handshake seen by the read-side sequencer.
// master = sequencer side, slave = FIFO / command consumer side.
interface fifo_rd_ctrl_if
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned WDATA_WIDTH = WDATA_WIDTH_DEF
);

    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   empty;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [WDATA_WIDTH-1:0] cmd_wdata;

    modport master (
        output rd_en,
        input  rd_data,
        input  empty,
        output cmd_valid,
        input  cmd_ready,
        output cmd_write,
        output cmd_addr,
        output cmd_wdata
    );

    modport slave (
        input  rd_en,
        output rd_data,
        output empty,
        input  cmd_valid,
        output cmd_ready,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_wdata
    );

endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side sequencer for the bridge async FIFO: pops entries, absorbs the
// one-cycle read latency and presents each entry over valid/ready.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned WDATA_WIDTH = WDATA_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 enable,
    input  logic                 flush,
    fifo_rd_ctrl_if.master       bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pop_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned W_BIT   = DATA_WIDTH - 1;
    localparam int unsigned A_MSB   = WDATA_WIDTH + ADDR_WIDTH - 1;
    localparam int unsigned A_LSB   = WDATA_WIDTH;
    localparam int unsigned D_MSB   = WDATA_WIDTH - 1;

    rd_ctrl_state_e         r_state;
    rd_ctrl_state_e         w_next_state;
    logic                   w_rd_en;
    logic                   w_capture;
    logic                   w_drop;
    logic                   r_cmd_valid;
    logic                   r_busy;
    logic [DATA_WIDTH-1:0]  r_entry;
    logic [CNT_WIDTH-1:0]   r_pop_count;
    logic [CNT_WIDTH-1:0]   r_drop_count;

    // State register
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pop strobe, next state, capture and drop decisions
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_drop       = 1'b0;
        w_rd_en      = enable & ~flush & ~bus.empty & ~rd_rst &
                       ((r_state == IDLE) | ((r_state == PRESENT) & bus.cmd_ready));

        if (flush) begin
            w_next_state = IDLE;
            w_drop       = (r_state == CAPTURE) |
                           ((r_state == PRESENT) & ~bus.cmd_ready);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rd_en) begin
                        w_next_state = CAPTURE;
                    end
                end
                CAPTURE: begin
                    w_capture    = 1'b1;
                    w_next_state = PRESENT;
                end
                PRESENT: begin
                    if (bus.cmd_ready) begin
                        w_next_state = w_rd_en ? CAPTURE : IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // Output register, status flags and statistics
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_cmd_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_entry      <= '0;
            r_pop_count  <= '0;
            r_drop_count <= '0;
        end else begin
            r_cmd_valid <= (w_next_state == PRESENT);
            r_busy      <= (w_next_state != IDLE);
            if (w_capture) begin
                r_entry <= bus.rd_data;
            end
            if (w_rd_en) begin
                r_pop_count <= r_pop_count + CNT_WIDTH'(1);
            end
            // drop_count saturates rather than wrapping
            if (w_drop && (r_drop_count != {CNT_WIDTH{1'b1}})) begin
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.rd_en     = w_rd_en;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_write = r_entry[W_BIT];
    assign bus.cmd_addr  = r_entry[A_MSB:A_LSB];
    assign bus.cmd_wdata = r_entry[D_MSB:0];
    assign busy          = r_busy;
    assign pop_count     = r_pop_count;
    assign drop_count    = r_drop_count;

endmodule
